// File: rtl/scale_bias_writeback_pkg.sv
// Shared definitions for the scale/bias writeback block: FSM state encoding,
// default parameter values and the signed saturation bounds of a feature word.
package scale_bias_writeback_pkg;

    localparam int SBW_TM_DEF            = 8;
    localparam int SBW_FEATURE_WIDTH_DEF = 16;
    localparam int SBW_SCALER_WIDTH_DEF  = 16;
    localparam int SBW_FRAC_SHIFT_DEF    = 8;
    localparam int SBW_ADDR_WIDTH_DEF    = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sbw_state_e;

    // Largest value representable in a signed word of the given width.
    function automatic longint satMax(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Most negative value representable in a signed word of the given width.
    function automatic longint satMin(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/sbw_scale_round_sat.sv
// Datapath of the writeback pipeline: registers the product of a channel sum
// and its scaler (stage 1), then rounds it down by FRAC_SHIFT (round-half-up),
// adds the bias and saturates to a signed feature word (stage 2, combinational
// into the caller's output register).
// Build option: define SBW_RELU_EN to clamp negative results to zero.
module sbw_scale_round_sat
    import scale_bias_writeback_pkg::*;
#(
    parameter int FEATURE_WIDTH = SBW_FEATURE_WIDTH_DEF,
    parameter int SCALER_WIDTH  = SBW_SCALER_WIDTH_DEF,
    parameter int FRAC_SHIFT    = SBW_FRAC_SHIFT_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             valid_i,
    input  logic signed [FEATURE_WIDTH-1:0]  data_i,
    input  logic signed [SCALER_WIDTH-1:0]   scaler_i,
    input  logic signed [FEATURE_WIDTH-1:0]  bias_i,
    output logic        [FEATURE_WIDTH-1:0]  result_o
);

    localparam int PW = FEATURE_WIDTH + SCALER_WIDTH;
    localparam int EW = PW + 2;

    localparam logic signed [EW-1:0] HALF    = EW'((longint'(1) <<< FRAC_SHIFT) >>> 1);
    localparam logic signed [EW-1:0] SAT_MAX = EW'(satMax(FEATURE_WIDTH));
    localparam logic signed [EW-1:0] SAT_MIN = EW'(satMin(FEATURE_WIDTH));

    logic signed [PW-1:0]            product_d;
    logic signed [PW-1:0]            product_q;
    logic signed [FEATURE_WIDTH-1:0] bias_q;
    logic signed [EW-1:0]            prodExt;
    logic signed [EW-1:0]            biasExt;
    logic signed [EW-1:0]            rounded;
    logic signed [EW-1:0]            sum;
    logic        [FEATURE_WIDTH-1:0] saturated;

    assign product_d = PW'(data_i) * PW'(scaler_i);

    // Stage 1: capture the full-width product together with the bias that
    // arrives alongside the scaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product_q <= '0;
            bias_q    <= '0;
        end else if (valid_i) begin
            product_q <= product_d;
            bias_q    <= bias_i;
        end
    end

    // Stage 2: round-half-up shift, bias add, clamp to the feature range.
    always_comb begin
        prodExt   = {{2{product_q[PW-1]}}, product_q};
        biasExt   = {{(EW-FEATURE_WIDTH){bias_q[FEATURE_WIDTH-1]}}, bias_q};
        rounded   = (prodExt + HALF) >>> FRAC_SHIFT;
        sum       = rounded + biasExt;
        saturated = sum[FEATURE_WIDTH-1:0];
        if (sum > SAT_MAX) begin
            saturated = FEATURE_WIDTH'(SAT_MAX);
        end else if (sum < SAT_MIN) begin
            saturated = FEATURE_WIDTH'(SAT_MIN);
        end
`ifdef SBW_RELU_EN
        result_o = saturated[FEATURE_WIDTH-1] ? '0 : saturated;
`else
        result_o = saturated;
`endif
    end

endmodule

// File: rtl/scale_bias_writeback.sv
// Scale/bias writeback: accepts channel-fastest signed sums for one tile,
// fetches each channel's scaler and bias, and writes the scaled, rounded,
// biased and saturated result into the channel's output bank at the pixel
// address, two cycles after each accept.
// Build option: define SBW_RELU_EN to clamp negative results to zero.
module scale_bias_writeback
    import scale_bias_writeback_pkg::*;
#(
    parameter int TM            = SBW_TM_DEF,
    parameter int FEATURE_WIDTH = SBW_FEATURE_WIDTH_DEF,
    parameter int SCALER_WIDTH  = SBW_SCALER_WIDTH_DEF,
    parameter int FRAC_SHIFT    = SBW_FRAC_SHIFT_DEF,
    parameter int ADDR_WIDTH    = SBW_ADDR_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(TM+1)-1:0]    cfg_channels,
    input  logic [ADDR_WIDTH:0]        cfg_pixels,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FEATURE_WIDTH-1:0]   in_data,
    output logic                       param_rd_en,
    output logic [$clog2(TM)-1:0]      param_addr,
    input  logic [SCALER_WIDTH-1:0]    scaler_data,
    input  logic [FEATURE_WIDTH-1:0]   bias_data,
    output logic [TM-1:0]              out_wr_en,
    output logic [ADDR_WIDTH-1:0]      out_addr,
    output logic [FEATURE_WIDTH-1:0]   out_data,
    output logic                       busy,
    output logic                       done
);

    localparam int CW  = $clog2(TM + 1);
    localparam int CHW = $clog2(TM);
    localparam logic [ADDR_WIDTH:0] PIX_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    sbw_state_e state_q;

    logic [CW-1:0]           cfgCh_q;
    logic [ADDR_WIDTH:0]     cfgPix_q;
    logic [CHW-1:0]          chCnt_q;
    logic [CHW-1:0]          chCnt_d;
    logic [ADDR_WIDTH-1:0]   pixCnt_q;
    logic [ADDR_WIDTH-1:0]   pixCnt_d;
    logic                    inReady_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    accept;
    logic                    cfgLegal;
    logic                    lastCh;
    logic                    lastPix;
    logic                    lastInput;
    logic                    pipeEmpty;

    logic                             s1Valid_q;
    logic [CHW-1:0]                   s1Ch_q;
    logic [ADDR_WIDTH-1:0]            s1Pix_q;
    logic signed [FEATURE_WIDTH-1:0]  s1Data_q;
    logic                             s2Valid_q;
    logic [CHW-1:0]                   s2Ch_q;
    logic [ADDR_WIDTH-1:0]            s2Pix_q;
    logic [FEATURE_WIDTH-1:0]         stageResult;

    logic [TM-1:0]                    outWrEn_q;
    logic [ADDR_WIDTH-1:0]            outAddr_q;
    logic [FEATURE_WIDTH-1:0]         outData_q;

    assign accept    = in_valid & inReady_q;
    assign cfgLegal  = (cfg_channels != '0) && (cfg_channels <= CW'(TM)) &&
                       (cfg_pixels != '0) && (cfg_pixels <= PIX_MAX);
    assign lastCh    = (CW'(chCnt_q) == (cfgCh_q - CW'(1)));
    assign lastPix   = ({1'b0, pixCnt_q} == (cfgPix_q - (ADDR_WIDTH+1)'(1)));
    assign pipeEmpty = ~s1Valid_q & ~s2Valid_q;

    assign in_ready    = inReady_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign param_rd_en = accept;
    assign param_addr  = chCnt_q;
    assign out_wr_en   = outWrEn_q;
    assign out_addr    = outAddr_q;
    assign out_data    = outData_q;

    // Next channel/pixel position after the current input is accepted;
    // channels wrap into the next pixel, the last pixel ends the tile.
    always_comb begin
        chCnt_d   = chCnt_q;
        pixCnt_d  = pixCnt_q;
        lastInput = 1'b0;
        if (lastCh) begin
            chCnt_d = '0;
            if (lastPix) begin
                pixCnt_d  = '0;
                lastInput = 1'b1;
            end else begin
                pixCnt_d = pixCnt_q + ADDR_WIDTH'(1);
            end
        end else begin
            chCnt_d = chCnt_q + CHW'(1);
        end
    end

    // Tile control FSM with registered handshake/status outputs and the
    // channel/pixel counters that address each accepted input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cfgCh_q   <= '0;
            cfgPix_q  <= '0;
            chCnt_q   <= '0;
            pixCnt_q  <= '0;
            inReady_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && cfgLegal) begin
                        cfgCh_q   <= cfg_channels;
                        cfgPix_q  <= cfg_pixels;
                        chCnt_q   <= '0;
                        pixCnt_q  <= '0;
                        inReady_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        chCnt_q  <= chCnt_d;
                        pixCnt_q <= pixCnt_d;
                        if (lastInput) begin
                            inReady_q <= 1'b0;
                            state_q   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pipeEmpty) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Carry each accepted input's channel, pixel and sum alongside the
    // parameter read so they meet the scaler and bias one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Ch_q    <= '0;
            s1Pix_q   <= '0;
            s1Data_q  <= '0;
            s2Valid_q <= 1'b0;
            s2Ch_q    <= '0;
            s2Pix_q   <= '0;
        end else begin
            s1Valid_q <= accept;
            if (accept) begin
                s1Ch_q   <= chCnt_q;
                s1Pix_q  <= pixCnt_q;
                s1Data_q <= $signed(in_data);
            end
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Ch_q  <= s1Ch_q;
                s2Pix_q <= s1Pix_q;
            end
        end
    end

    sbw_scale_round_sat #(
        .FEATURE_WIDTH (FEATURE_WIDTH),
        .SCALER_WIDTH  (SCALER_WIDTH),
        .FRAC_SHIFT    (FRAC_SHIFT)
    ) uScaleRoundSat (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (s1Valid_q),
        .data_i   (s1Data_q),
        .scaler_i ($signed(scaler_data)),
        .bias_i   ($signed(bias_data)),
        .result_o (stageResult)
    );

    // Register the bank write: one-hot enable for the result's channel,
    // with address and data held between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outWrEn_q <= '0;
            outAddr_q <= '0;
            outData_q <= '0;
        end else begin
            outWrEn_q <= s2Valid_q ? (TM'(1) << s2Ch_q) : '0;
            if (s2Valid_q) begin
                outAddr_q <= s2Pix_q;
                outData_q <= stageResult;
            end
        end
    end

endmodule

// File: tb/tb_scale_bias_writeback.sv
// Directed bench for scale_bias_writeback with TM=8, 16-bit data, FRAC_SHIFT=8.
// A small parameter memory answers reads one cycle later; a monitor logs every
// bank write, accept and done pulse by cycle number for the scenario tasks.
module tb_scale_bias_writeback;

    typedef struct {
        int          bank;
        int          addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  cfg_channels;
    logic [10:0] cfg_pixels;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        param_rd_en;
    logic [2:0]  param_addr;
    logic [15:0] scaler_data;
    logic [15:0] bias_data;
    logic [7:0]  out_wr_en;
    logic [9:0]  out_addr;
    logic [15:0] out_data;
    logic        busy;
    logic        done;

    logic [15:0] scalerMem [8];
    logic [15:0] biasMem [8];
    logic [15:0] feedQ [$];
    wr_t         wrQ [$];
    int          accQ [$];
    int          doneQ [$];
    int          cyc = 0;
    int          multiHot = 0;
    int          nVec = 0;
    int          nErr = 0;

    scale_bias_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_channels (cfg_channels),
        .cfg_pixels   (cfg_pixels),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .param_rd_en  (param_rd_en),
        .param_addr   (param_addr),
        .scaler_data  (scaler_data),
        .bias_data    (bias_data),
        .out_wr_en    (out_wr_en),
        .out_addr     (out_addr),
        .out_data     (out_data),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter: value N after the N-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Parameter memory with one-cycle read latency.
    always @(posedge clk) begin
        if (param_rd_en) begin
            scaler_data <= scalerMem[param_addr];
            bias_data   <= biasMem[param_addr];
        end
    end

    // Log accepts (for the coming edge), writes and done pulses.
    always @(negedge clk) begin
        wr_t w;
        if (in_valid === 1'b1 && in_ready === 1'b1) accQ.push_back(cyc + 1);
        if (out_wr_en !== 8'h00) begin
            if ($countones(out_wr_en) != 1) multiHot++;
            w.bank = -1;
            for (int b = 0; b < 8; b++) if (out_wr_en[b]) w.bank = b;
            w.addr = int'(out_addr);
            w.data = out_data;
            w.cyc  = cyc;
            wrQ.push_back(w);
        end
        if (done === 1'b1) doneQ.push_back(cyc);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clearLogs();
        wrQ.delete();
        accQ.delete();
        doneQ.delete();
        multiHot = 0;
    endtask

    task automatic doStart(input int ch, input int pix);
        cfg_channels = 4'(ch);
        cfg_pixels   = 11'(pix);
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
    endtask

    task automatic feed(input bit gaps, output bit timedOut);
        int budget;
        timedOut = 1'b0;
        foreach (feedQ[i]) begin
            in_data  = feedQ[i];
            in_valid = 1'b1;
            budget   = 50;
            while (in_ready !== 1'b1 && budget > 0) begin
                @(posedge clk); #1;
                budget--;
            end
            if (budget == 0) begin
                timedOut = 1'b1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (gaps) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDone(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        cfg_channels = '0; cfg_pixels = '0;
        repeat (3) @(posedge clk); #1;
        nVec++;
        if ({in_ready, param_rd_en, busy, done} !== 4'b0000) begin
            nErr++;
            $display("[TB] FAIL reset_ctrl: in_ready/param_rd_en/busy/done=%b, expected 0000",
                     {in_ready, param_rd_en, busy, done});
        end
        nVec++;
        if (out_wr_en !== 8'h00) begin
            nErr++;
            $display("[TB] FAIL reset_wr_en: got %h, expected 00", out_wr_en);
        end
        nVec++;
        if (param_addr !== 3'd0 || out_addr !== 10'd0 || out_data !== 16'd0) begin
            nErr++;
            $display("[TB] FAIL reset_addr_data: param_addr=%0d out_addr=%0d out_data=%h, expected 0/0/0000",
                     param_addr, out_addr, out_data);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        nVec++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL post_reset_idle: busy=%b in_ready=%b, expected 0/0", busy, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        bit to, seen;
        int n, lat;
        for (int c = 0; c < 8; c++) begin scalerMem[c] = 16'd256; biasMem[c] = 16'd1; end
        clearLogs();
        doStart(8, 2);
        nVec++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            nErr++;
            $display("[TB] FAIL b2b_run_entry: busy=%b in_ready=%b, expected 1/1", busy, in_ready);
        end
        feedQ.delete();
        for (int i = 0; i < 16; i++) feedQ.push_back(16'd256);
        feed(1'b0, to);
        waitDone(20, seen);
        nVec++;
        if (to || !seen) begin
            nErr++;
            $display("[TB] FAIL b2b_complete: timeout=%b done_seen=%b, expected 0/1", to, seen);
        end
        nVec++;
        if (wrQ.size() != 16) begin
            nErr++;
            $display("[TB] FAIL b2b_count: got %0d writes, expected 16", wrQ.size());
        end
        n = (wrQ.size() < 16) ? wrQ.size() : 16;
        for (int i = 0; i < n; i++) begin
            lat = (i < accQ.size()) ? wrQ[i].cyc - accQ[i] : -1;
            nVec++;
            if (wrQ[i].bank != i % 8 || wrQ[i].addr != i / 8 || wrQ[i].data !== 16'd257 || lat != 2) begin
                nErr++;
                $display("[TB] FAIL b2b_wr%0d: bank=%0d addr=%0d data=%0d lat=%0d, expected %0d/%0d/257/2",
                         i, wrQ[i].bank, wrQ[i].addr, $signed(wrQ[i].data), lat, i % 8, i / 8);
            end
        end
        nVec++;
        if (!(accQ.size() == 16 && accQ[15] - accQ[0] == 15)) begin
            nErr++;
            $display("[TB] FAIL b2b_throughput: %0d accepts, expected 16 on consecutive cycles", accQ.size());
        end
        nVec++;
        if (!(doneQ.size() == 1 && accQ.size() == 16 && doneQ[0] - accQ[15] == 3)) begin
            nErr++;
            $display("[TB] FAIL b2b_done: %0d done pulses (first at %0d), expected 1 pulse 3 cycles after last accept",
                     doneQ.size(), (doneQ.size() > 0) ? doneQ[0] : -1);
        end
        nVec++;
        if (multiHot != 0 || busy !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL b2b_onehot_idle: multiHot=%0d busy=%b, expected 0/0", multiHot, busy);
        end
    endtask

    task automatic test_arithmetic();
        logic [15:0] dIn [8];
        logic [15:0] sIn [8];
        logic [15:0] bIn [8];
        logic [15:0] expD [8];
        bit to, seen;
        int n;
        dIn = '{16'sd32767, -16'sd32768, 16'sd1, 16'sd1, -16'sd1, -16'sd3, 16'sd32767, -16'sd32768};
        sIn = '{16'sd32767, 16'sd32767, 16'sd128, 16'sd127, 16'sd128, 16'sd128, 16'sd256, 16'sd256};
        bIn = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd5, 16'sd100, -16'sd1};
`ifdef SBW_RELU_EN
        expD = '{16'sd32767, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd4, 16'sd32767, 16'sd0};
`else
        expD = '{16'sd32767, -16'sd32768, 16'sd1, 16'sd0, 16'sd0, 16'sd4, 16'sd32767, -16'sd32768};
`endif
        for (int c = 0; c < 8; c++) begin scalerMem[c] = sIn[c]; biasMem[c] = bIn[c]; end
        clearLogs();
        doStart(8, 1);
        feedQ.delete();
        for (int i = 0; i < 8; i++) feedQ.push_back(dIn[i]);
        feed(1'b0, to);
        waitDone(20, seen);
        nVec++;
        if (to || !seen || wrQ.size() != 8) begin
            nErr++;
            $display("[TB] FAIL arith_complete: timeout=%b done_seen=%b writes=%0d, expected 0/1/8",
                     to, seen, wrQ.size());
        end
        n = (wrQ.size() < 8) ? wrQ.size() : 8;
        for (int i = 0; i < n; i++) begin
            nVec++;
            if (wrQ[i].bank != i || wrQ[i].addr != 0 || wrQ[i].data !== expD[i]) begin
                nErr++;
                $display("[TB] FAIL arith_ch%0d: bank=%0d addr=%0d data=%0d, expected %0d/0/%0d",
                         i, wrQ[i].bank, wrQ[i].addr, $signed(wrQ[i].data), i, $signed(expD[i]));
            end
        end
    endtask

    task automatic test_gaps();
        bit to, seen;
        int n, lat;
        logic [15:0] expV;
        for (int c = 0; c < 8; c++) begin
            scalerMem[c] = 16'd256;
            biasMem[c]   = 16'(c * 100);
        end
        clearLogs();
        doStart(3, 4);
        feedQ.delete();
        for (int i = 0; i < 12; i++) feedQ.push_back(16'(i * 7));
        feed(1'b1, to);
        waitDone(20, seen);
        nVec++;
        if (to || !seen || wrQ.size() != 12) begin
            nErr++;
            $display("[TB] FAIL gaps_complete: timeout=%b done_seen=%b writes=%0d, expected 0/1/12",
                     to, seen, wrQ.size());
        end
        n = (wrQ.size() < 12) ? wrQ.size() : 12;
        for (int i = 0; i < n; i++) begin
            expV = 16'(i * 7 + (i % 3) * 100);
            lat  = (i < accQ.size()) ? wrQ[i].cyc - accQ[i] : -1;
            nVec++;
            if (wrQ[i].bank != i % 3 || wrQ[i].addr != i / 3 || wrQ[i].data !== expV || lat != 2) begin
                nErr++;
                $display("[TB] FAIL gaps_wr%0d: bank=%0d addr=%0d data=%0d lat=%0d, expected %0d/%0d/%0d/2",
                         i, wrQ[i].bank, wrQ[i].addr, $signed(wrQ[i].data), lat, i % 3, i / 3, expV);
            end
        end
        nVec++;
        if (!(doneQ.size() == 1 && accQ.size() == 12 && doneQ[0] - accQ[11] == 3) || multiHot != 0) begin
            nErr++;
            $display("[TB] FAIL gaps_done: done pulses=%0d accepts=%0d multiHot=%0d, expected 1/12/0",
                     doneQ.size(), accQ.size(), multiHot);
        end
    endtask

    task automatic test_ignored_start();
        int badCh [4];
        int badPix [4];
        bit to, seen;
        badCh  = '{0, 9, 2, 1};
        badPix = '{4, 4, 0, 1025};
        clearLogs();
        for (int k = 0; k < 4; k++) begin
            doStart(badCh[k], badPix[k]);
            repeat (3) @(posedge clk); #1;
            nVec++;
            if (busy !== 1'b0 || in_ready !== 1'b0) begin
                nErr++;
                $display("[TB] FAIL illegal_cfg%0d: busy=%b in_ready=%b, expected 0/0", k, busy, in_ready);
            end
        end
        nVec++;
        if (wrQ.size() != 0 || doneQ.size() != 0) begin
            nErr++;
            $display("[TB] FAIL illegal_cfg_quiet: writes=%0d done=%0d, expected 0/0", wrQ.size(), doneQ.size());
        end
        for (int c = 0; c < 8; c++) begin scalerMem[c] = 16'd256; biasMem[c] = 16'd0; end
        clearLogs();
        doStart(2, 1);
        doStart(8, 5);
        feedQ.delete();
        feedQ.push_back(16'd512);
        feedQ.push_back(16'd300);
        feed(1'b0, to);
        waitDone(20, seen);
        nVec++;
        if (to || !seen || wrQ.size() != 2 || doneQ.size() != 1) begin
            nErr++;
            $display("[TB] FAIL busy_start: timeout=%b done_seen=%b writes=%0d dones=%0d, expected 0/1/2/1",
                     to, seen, wrQ.size(), doneQ.size());
        end else begin
            nVec++;
            if (wrQ[0].bank != 0 || wrQ[0].data !== 16'd512 || wrQ[1].bank != 1 || wrQ[1].data !== 16'd300) begin
                nErr++;
                $display("[TB] FAIL busy_start_data: %0d@%0d %0d@%0d, expected 512@0 300@1",
                         wrQ[0].data, wrQ[0].bank, wrQ[1].data, wrQ[1].bank);
            end
        end
    endtask

    task automatic test_reset_mid_tile();
        bit to, seen;
        for (int c = 0; c < 8; c++) begin scalerMem[c] = 16'd256; biasMem[c] = 16'd0; end
        clearLogs();
        doStart(8, 2);
        in_data  = 16'd100;
        in_valid = 1'b1;
        repeat (5) @(posedge clk); #1;
        nVec++;
        if (accQ.size() != 5 || out_wr_en !== 8'h04) begin
            nErr++;
            $display("[TB] FAIL midrst_setup: accepts=%0d out_wr_en=%h, expected 5/04", accQ.size(), out_wr_en);
        end
        rst = 1'b1;
        #1;
        nVec++;
        if ({in_ready, param_rd_en, busy, done} !== 4'b0000 || out_wr_en !== 8'h00) begin
            nErr++;
            $display("[TB] FAIL midrst_ctrl: ctrl=%b out_wr_en=%h, expected 0000/00",
                     {in_ready, param_rd_en, busy, done}, out_wr_en);
        end
        nVec++;
        if (out_data !== 16'd0 || out_addr !== 10'd0 || param_addr !== 3'd0) begin
            nErr++;
            $display("[TB] FAIL midrst_data: out_data=%h out_addr=%0d param_addr=%0d, expected 0/0/0",
                     out_data, out_addr, param_addr);
        end
        clearLogs();
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk); #1;
        nVec++;
        if (wrQ.size() != 0 || doneQ.size() != 0 || accQ.size() != 0 || in_ready !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL midrst_quiet: writes=%0d dones=%0d accepts=%0d in_ready=%b, expected 0/0/0/0",
                     wrQ.size(), doneQ.size(), accQ.size(), in_ready);
        end
        in_valid = 1'b0;
        clearLogs();
        doStart(1, 1);
        feedQ.delete();
        feedQ.push_back(16'd77);
        feed(1'b0, to);
        waitDone(20, seen);
        nVec++;
        if (to || !seen || wrQ.size() != 1 || (wrQ.size() == 1 && (wrQ[0].data !== 16'd77 || wrQ[0].bank != 0))) begin
            nErr++;
            $display("[TB] FAIL midrst_restart: timeout=%b done_seen=%b writes=%0d, expected 0/1/1 write of 77 to bank 0",
                     to, seen, wrQ.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_arithmetic();
        test_gaps();
        test_ignored_start();
        test_reset_mid_tile();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/scale_bias_writeback.md
SCALE_BIAS_WRITEBACK -- requirements
Module: scale_bias_writeback

Interface
REQ-001 Parameters SHALL be: TM (default 8), number of output channel banks; FEATURE_WIDTH (16), signed feature width; SCALER_WIDTH (16), signed scaler width; FRAC_SHIFT (8), right-shift applied to the scaled product; ADDR_WIDTH (10), bank address width.
REQ-002 Ports SHALL be, one per line, as follows.
REQ-003 clk in 1: clock.
REQ-004 rst in 1: reset, asynchronous, active-high.
REQ-005 start in 1: one-cycle pulse; samples cfg_channels and cfg_pixels.
REQ-006 cfg_channels in clog2(TM+1): number of active channels, legal range 1..TM.
REQ-007 cfg_pixels in ADDR_WIDTH+1: pixels per tile, legal range 1..2^ADDR_WIDTH.
REQ-008 in_valid in 1: input sum valid.
REQ-009 in_ready out 1: input accepted when in_valid&in_ready.
REQ-010 in_data in FEATURE_WIDTH: signed channel sum.
REQ-011 param_rd_en out 1: scaler/bias read strobe.
REQ-012 param_addr out clog2(TM): channel index for scaler and bias.
REQ-013 scaler_data in SCALER_WIDTH: returned one cycle after param_rd_en.
REQ-014 bias_data in FEATURE_WIDTH: returned one cycle after param_rd_en.
REQ-015 out_wr_en out TM: one-hot bank write enable.
REQ-016 out_addr out ADDR_WIDTH: pixel index.
REQ-017 out_data out FEATURE_WIDTH: result.
REQ-018 busy out 1: tile in progress.
REQ-019 done out 1: one-cycle pulse at completion.

Function
REQ-020 The FSM SHALL have states IDLE, RUN, DRAIN, DONE.
REQ-021 IDLE->RUN on start when the sampled cfg values are legal; an illegal cfg SHALL leave the FSM in IDLE.
REQ-022 RUN->DRAIN on the accept of the final input (channel cfg_channels-1, pixel cfg_pixels-1).
REQ-023 DRAIN->DONE when the pipeline is empty; DONE->IDLE after one cycle, during which done=1.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 in_ready SHALL equal 1 only in RUN.
REQ-026 Input order SHALL be channel-fastest: ch 0..cfg_channels-1 for pixel 0, then pixel 1, and so on.
REQ-027 Stage 0 (accept): param_rd_en=1 and param_addr=ch in the same cycle; ch/pixel are registered.
REQ-028 Stage 1: product = in_data*scaler_data, full signed width FEATURE_WIDTH+SCALER_WIDTH.
REQ-029 Stage 2: arithmetic right shift by FRAC_SHIFT with round-half-up, add bias, saturate to signed FEATURE_WIDTH; write with out_wr_en[ch]=1, out_addr=pixel.
REQ-030 Latency SHALL be exactly 2 cycles from the accept edge to the out_wr_en cycle; throughput one input per cycle.
REQ-031 Channel counter SHALL wrap at cfg_channels-1 to 0 and increment pixel; pixel SHALL not wrap within a tile.
REQ-032 out_wr_en SHALL be all zero except on valid stage-2 cycles; never more than one bit set.
REQ-033 busy SHALL be 1 in RUN and DRAIN.

Reset
REQ-034 On rst, state=IDLE, counters and pipeline valids=0.
REQ-035 On rst, in_ready, param_rd_en, out_wr_en, done and busy SHALL be 0.
REQ-036 On rst, param_addr, out_addr and out_data SHALL be 0.
REQ-037 rst mid-tile SHALL abort the tile with no further writes; a new start is needed.

Configuration
REQ-038 With SBW_RELU_EN defined, stage 2 SHALL clamp negative saturated results to 0 before the write.
REQ-039 Without SBW_RELU_EN, the signed saturated result SHALL be written unchanged; no extra latency in either case.

Structure
REQ-040 A shared package/header SHALL hold the FSM state encoding, the default parameter values, and the saturation bounds derived from FEATURE_WIDTH.
REQ-041 One sub-module, sbw_scale_round_sat (multiply, round-shift, bias, saturate, optional ReLU), is natural; the FSM, counters and bank decode stay top-level.

Verification
REQ-042 TM=8, cfg_channels=8, cfg_pixels=2, 16 back-to-back inputs of 256, scaler=256, bias=1 -> 16 writes of 257, out_wr_en cycling 0x01..0x80, addr 0 then 1, done pulse 3 cycles after the last accept.
REQ-043 in_data=32767, scaler=32767, bias=0 -> out_data=32767 (saturate); in_data=-32768, scaler=32767 -> -32768 without RELU, 0 with SBW_RELU_EN.
REQ-044 Rounding: in_data=1, scaler=128, FRAC_SHIFT=8 -> 1; scaler=127 -> 0.
REQ-045 cfg_channels=3, cfg_pixels=4 with in_valid gaps -> 12 writes, only banks 0-2, addresses 0..3, correct order.
REQ-046 start while busy, and start with cfg_channels=0 -> ignored, no writes, no done.
REQ-047 rst asserted after 5 accepts -> outputs 0 immediately, no later writes, in_ready=0 until the next start.
